alu_multicycle: RTL and testbench

- Parametrised successor to the single-cycle SimpleRISC ALU.
- Executes the same 4-bit ALU_* operation set from decode.vh at a configurable data width.
- Runs MUL, DIV and MOD iteratively: shift-add for MUL, restoring division for DIV/MOD. Other ops take one cycle.
- Sits between the execute-stage operand latch and writeback. It uses a valid/ready handshake so the pipeline can stall on long operations.

---
 rtl/alu_multicycle_pkg.sv | 23 ++
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle_div_iter.sv | 64 ++++++
 rtl/alu_multicycle.sv | 170 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_multicycle_pkg.sv
// ALU opcode set shared by decode and the multicycle ALU; 14 and 15 are unassigned.
package alu_multicycle_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_MUL  = 4'h9;
  localparam logic [3:0] ALU_DIV  = 4'hA;
  localparam logic [3:0] ALU_MOD  = 4'hB;
  localparam logic [3:0] ALU_NOT  = 4'hC;
  localparam logic [3:0] ALU_PASS = 4'hD;

  function automatic logic is_divide(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the operand latch, the ALU and writeback.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, a, b, op, flush, out_ready,
    input  in_ready, out_valid, y, zero, busy
  );

  modport slave (
    input  in_valid, a, b, op, flush, out_ready,
    output in_ready, out_valid, y, zero, busy
  );
endinterface

// File: rtl/alu_multicycle_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after i_start.
// o_done pulses during the last iteration with o_quot/o_rem showing the final values.
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);
  localparam int CW = $clog2(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_rem_nxt;

  // Trial needs one extra bit: the shifted remainder can exceed WIDTH bits before subtraction.
  always_comb begin
    w_trial   = {r_rem, r_quo[WIDTH-1]};
    w_fits    = (w_trial >= {1'b0, r_dvs});
    w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
    w_rem_nxt = w_fits ? WIDTH'(w_trial - {1'b0, r_dvs}) : w_trial[WIDTH-1:0];
  end

  assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_quot = w_quo_nxt;
  assign o_rem  = w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (i_abort) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops in 1 cycle, MUL/DIV/MOD iterate WIDTH cycles.
// Result held in DONE until out_ready or flush; in_ready only in IDLE.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  alu_multicycle_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_y_load;
  logic             r_is_mod;

  logic             w_mul_start;
  logic             w_div_start;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_mul_last;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_single;

  logic             w_div_done;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (bus.flush),
    .i_dividend (bus.a),
    .i_divisor  (bus.b),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_shamt = bus.b[SHW-1:0];

  always_comb begin
    w_single = '0;
    case (bus.op)
      ALU_ADD:  w_single = bus.a + bus.b;
      ALU_SUB:  w_single = bus.a - bus.b;
      ALU_AND:  w_single = bus.a & bus.b;
      ALU_OR:   w_single = bus.a | bus.b;
      ALU_XOR:  w_single = bus.a ^ bus.b;
      ALU_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLL:  w_single = bus.a << w_shamt;
      ALU_SRL:  w_single = bus.a >> w_shamt;
      ALU_SRA:  w_single = $unsigned($signed(bus.a) >>> w_shamt);
      ALU_NOT:  w_single = ~bus.b;
      ALU_PASS: w_single = bus.b;
      default:  w_single = '0;
    endcase
  end

  // Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
  assign w_acc_nxt  = r_acc + (r_mb[0] ? r_ma : '0);
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma  <= '0;
      r_mb  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_mul_start) begin
      r_ma  <= bus.a;
      r_mb  <= bus.b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_y_load    = 1'b0;
    w_mul_start = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          if (bus.op == ALU_MUL) begin
            w_state_nxt = S_MUL;
            w_mul_start = 1'b1;
          end else if (is_divide(bus.op)) begin
            if (bus.b == '0) begin
              w_y_load    = 1'b1;
              w_y_nxt     = (bus.op == ALU_DIV) ? '1 : bus.a;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_DIV;
              w_div_start = 1'b1;
            end
          end else begin
            w_y_load    = 1'b1;
            w_y_nxt     = w_single;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_mul_last) begin
          w_y_load    = 1'b1;
          w_y_nxt     = w_acc_nxt;
          w_state_nxt = S_DONE;
        end
      end
      S_DIV: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_div_done) begin
          w_y_load    = 1'b1;
          w_y_nxt     = r_is_mod ? w_rem : w_quot;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.flush || bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_y      <= '0;
      r_is_mod <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_y_load)    r_y      <= w_y_nxt;
      if (w_div_start) r_is_mod <= (bus.op == ALU_MOD);
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign bus.y         = r_y;
  assign bus.zero      = (r_y == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] sb_q[$];

  alu_multicycle_if #(.WIDTH(32)) bus ();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $signed(a) >>> sh;
      ALU_MUL:  r = a * b;
      ALU_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_MOD:  r = (b == 0) ? a : a % b;
      ALU_NOT:  r = ~b;
      ALU_PASS: r = b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  // Issue one op, measure latency/busy, check result, hold out_ready low for 'hold' cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] exp_y;
    logic [31:0] held_y;
    int          lat;
    int          nbusy;
    int          exp_lat;
    logic        stable;
    exp_lat = (op == ALU_MUL || ((op == ALU_DIV || op == ALU_MOD) && b != 0)) ? 33 : 1;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (hold == 0);
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!bus.out_valid && lat < 100) begin
      nbusy += int'(bus.busy);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    exp_y = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, ".y"}, bus.y, exp_y);
    chk({tag, ".zero"}, 32'(bus.zero), 32'(exp_y == 32'd0));
    held_y = bus.y;
    stable = 1'b1;
    repeat (hold) begin
      if (bus.y !== held_y || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk({tag, ".held_stable"}, 32'(stable), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = ALU_ADD;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.y", bus.y, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(ALU_ADD,  32'hFFFF_FFFF, 32'd1,          0, "add_wrap");
    run_op(ALU_MUL,  32'h0001_2345, 32'h0001_0000, 0, "mul");
    run_op(ALU_DIV,  32'd100,       32'd7,          0, "div");
    run_op(ALU_MOD,  32'd100,       32'd7,          0, "mod");
    run_op(ALU_DIV,  32'd5,         32'd0,          0, "div_by0");
    run_op(ALU_MOD,  32'd5,         32'd0,          0, "mod_by0");
    run_op(ALU_SUB,  32'd0,         32'd1,          0, "sub_wrap");
    run_op(ALU_SLT,  32'd5,         32'hFFFF_FFFD,  0, "slt_neg_b");
    run_op(ALU_SLL,  32'h0000_00F1, 32'h0000_0124,  0, "sll");
    run_op(ALU_SRL,  32'h8000_0000, 32'd31,         0, "srl");
    run_op(ALU_XOR,  32'hA5A5_0F0F, 32'hFFFF_0000,  0, "xor");
    run_op(ALU_NOT,  32'h1234_5678, 32'h0F0F_0F0F,  0, "not");
    run_op(ALU_PASS, 32'h1234_5678, 32'hCAFE_F00D,  0, "pass");
    run_op(4'hF,     32'h1234_5678, 32'h1111_1111,  0, "undef_op");
    run_op(ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  0, "mul_wrap");
    run_op(ALU_DIV,  32'hFFFF_FFFF, 32'h0000_0010,  0, "div_big");
    run_op(ALU_MOD,  32'hFFFF_FFFF, 32'h0000_0010,  0, "mod_big");
    run_op(ALU_DIV,  32'd3,         32'd10,         0, "div_small");
    run_op(ALU_SRA,  32'h8000_0000, 32'd4,         10, "sra_bp");

    // Flush in IDLE must win over a simultaneous in_valid.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = ALU_ADD;
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_idle.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_idle.in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_idle.busy", 32'(bus.busy), 32'd0);

    // Flush five cycles into a DIV.
    bus.in_valid  = 1'b1;
    bus.op        = ALU_DIV;
    bus.a         = 32'd100;
    bus.b         = 32'd7;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("flush_div.busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_div.busy", 32'(bus.busy), 32'd0);
    chk("flush_div.in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("flush_div.no_out_valid", 32'(seen), 32'd0);
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, "slt_after_flush");

    // Asynchronous reset between edges in the middle of a MUL.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = ALU_MUL;
    bus.a        = 32'd3;
    bus.b        = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mul.busy_before", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mul.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mul.busy", 32'(bus.busy), 32'd0);
    chk("rst_mul.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mul.y", bus.y, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("rst_mul.no_stale_valid", 32'(seen), 32'd0);
    run_op(ALU_ADD, 32'd3, 32'd4, 0, "add_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
